// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one main-memory word port between the I-cache line-fill engine and
// the D-cache fill/write-back engine. A whole line is moved as LINE_WORDS
// word transfers, and each transfer is closed by mem_ack. D has priority.
// After STARVE_LIMIT consecutive D grants made while I is waiting, I is
// granted next.
//
// Ports:
//   Clk, Reset_N            clock, synchronous active-low reset
//   i_req/i_addr            I-side line read request and line address
//   i_rdata/i_done          I-side filled line and one-cycle completion pulse
//   d_req/d_we/d_addr       D-side request (we=1 write-back, we=0 fill)
//   d_wdata                 D-side write-back line
//   d_rdata/d_done          D-side filled line and one-cycle completion pulse
//   mem_readM/mem_writeM    memory strobes, held for the whole line
//   mem_address/mem_wdata   current word address and write word
//   mem_rdata/mem_ack       memory read word and per-word completion
//   busy/owner              arbiter active, current owner (0 = I, 1 = D)
//
// State table:
//   IDLE | sample requests, arbitrate, latch the winning request
//   XFER | move one word per mem_ack, from word 0 to word LINE_WORDS-1
//   DONE | pulse the owner's done for one cycle, then return to IDLE
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int LINE_WORDS   = 4,
    parameter int STARVE_LIMIT = 2
) (
    input  logic                            Clk,
    input  logic                            Reset_N,
    input  logic                            i_req,
    input  logic [WORD_SIZE-1:0]            i_addr,
    output logic [WORD_SIZE*LINE_WORDS-1:0] i_rdata,
    output logic                            i_done,
    input  logic                            d_req,
    input  logic                            d_we,
    input  logic [WORD_SIZE-1:0]            d_addr,
    input  logic [WORD_SIZE*LINE_WORDS-1:0] d_wdata,
    output logic [WORD_SIZE*LINE_WORDS-1:0] d_rdata,
    output logic                            d_done,
    output logic                            mem_readM,
    output logic                            mem_writeM,
    output logic [WORD_SIZE-1:0]            mem_address,
    output logic [WORD_SIZE-1:0]            mem_wdata,
    input  logic [WORD_SIZE-1:0]            mem_rdata,
    input  logic                            mem_ack,
    output logic                            busy,
    output logic                            owner
);

    localparam int LINE_W = WORD_SIZE * LINE_WORDS;
    localparam int IDX_W  = $clog2(LINE_WORDS);
    localparam int SC_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]      STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(LINE_WORDS - 1);
    localparam logic [WORD_SIZE-1:0] LOW_MASK   = WORD_SIZE'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [SC_W-1:0]       starve_q;
    logic [SC_W-1:0]       starve_d;
    logic                  we_q;
    logic [WORD_SIZE-1:0]  base_q;
    logic [LINE_W-1:0]     wdata_q;
    logic [LINE_W-1:0]     i_rdata_q;
    logic [LINE_W-1:0]     d_rdata_q;
    logic                  i_done_q;
    logic                  d_done_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [WORD_SIZE-1:0]  mem_address_q;
    logic [WORD_SIZE-1:0]  mem_wdata_q;
    logic                  busy_q;
    logic                  owner_q;

    logic                  i_forced;
    logic                  grant_dc;
    logic                  grant_ic;
    logic                  grant_we;
    logic [WORD_SIZE-1:0]  base_d;
    logic [IDX_W-1:0]      idx_d;

    // I wins over a pending D only once D has used up its consecutive grants.
    assign i_forced = i_req && (starve_q == STARVE_MAX);
    assign grant_dc = d_req && !i_forced;
    assign grant_ic = !grant_dc && i_req;
    assign grant_we = grant_dc && d_we;
    assign base_d   = (grant_dc ? d_addr : i_addr) & ~LOW_MASK;
    assign idx_d    = idx_q + IDX_W'(1);

    always_comb begin
        starve_d = starve_q;
        if (grant_ic)
            starve_d = '0;
        else if (grant_dc && i_req && (starve_q != STARVE_MAX))
            starve_d = starve_q + SC_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            starve_q      <= '0;
            we_q          <= 1'b0;
            base_q        <= '0;
            wdata_q       <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            busy_q        <= 1'b0;
            owner_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    if (grant_dc || grant_ic) begin
                        state_q       <= XFER;
                        busy_q        <= 1'b1;
                        owner_q       <= grant_dc;
                        we_q          <= grant_we;
                        base_q        <= base_d;
                        wdata_q       <= grant_dc ? d_wdata : '0;
                        idx_q         <= '0;
                        starve_q      <= starve_d;
                        mem_address_q <= base_d;
                        mem_wdata_q   <= grant_dc ? d_wdata[WORD_SIZE-1:0] : '0;
                        mem_read_q    <= !grant_we;
                        mem_write_q   <= grant_we;
                    end
                end
                XFER: begin
                    if (mem_ack) begin
                        if (!we_q) begin
                            if (owner_q)
                                d_rdata_q[int'(idx_q)*WORD_SIZE +: WORD_SIZE] <= mem_rdata;
                            else
                                i_rdata_q[int'(idx_q)*WORD_SIZE +: WORD_SIZE] <= mem_rdata;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q     <= DONE;
                            mem_read_q  <= 1'b0;
                            mem_write_q <= 1'b0;
                            i_done_q    <= !owner_q;
                            d_done_q    <= owner_q;
                        end else begin
                            idx_q         <= idx_d;
                            mem_address_q <= base_q | WORD_SIZE'(idx_d);
                            mem_wdata_q   <= wdata_q[int'(idx_d)*WORD_SIZE +: WORD_SIZE];
                        end
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign i_done      = i_done_q;
    assign d_done      = d_done_q;
    assign mem_readM   = mem_read_q;
    assign mem_writeM  = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;
    assign owner       = owner_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Directed bench for cache_mem_arbiter. A memory responder acknowledges each
// word a programmable number of cycles after its address appears and returns
// address + 0x0100 as read data. It also logs every acknowledged word and
// every grant.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    logic        Clk;
    logic        Reset_N;
    logic        i_req;
    logic [15:0] i_addr;
    logic [63:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_done;
    logic        mem_readM;
    logic        mem_writeM;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        owner;

    logic        ack_r;
    logic        spur_ack;
    int          resp_lat;
    int          wait_cnt;
    logic        busy_prev;
    int          i_done_cnt;
    int          d_done_cnt;
    logic [1:0]  starve_at_i;
    logic        grant_q[$];
    logic [15:0] log_addr[$];
    logic [15:0] log_wdata[$];
    logic        log_we[$];

    int          checks;
    int          errors;

    assign mem_ack = ack_r | spur_ack;

    cache_mem_arbiter #(
        .WORD_SIZE    (16),
        .LINE_WORDS   (4),
        .STARVE_LIMIT (2)
    ) dut (
        .Clk         (Clk),
        .Reset_N     (Reset_N),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_done      (i_done),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_done      (d_done),
        .mem_readM   (mem_readM),
        .mem_writeM  (mem_writeM),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .owner       (owner)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Responder and monitor: runs 1 time unit after each rising edge.
    initial begin
        ack_r      = 1'b0;
        mem_rdata  = '0;
        wait_cnt   = 0;
        busy_prev  = 1'b0;
        i_done_cnt = 0;
        d_done_cnt = 0;
        starve_at_i = 2'd3;
        forever begin
            @(posedge Clk);
            #1;
            if (i_done) i_done_cnt++;
            if (d_done) d_done_cnt++;
            if (busy && !busy_prev) begin
                grant_q.push_back(owner);
                if (!owner) starve_at_i = dut.starve_q;
            end
            busy_prev = busy;
            if (mem_readM || mem_writeM) begin
                if (wait_cnt == resp_lat) begin
                    ack_r     = 1'b1;
                    mem_rdata = mem_address + 16'h0100;
                    log_addr.push_back(mem_address);
                    log_wdata.push_back(mem_wdata);
                    log_we.push_back(mem_writeM);
                    wait_cnt  = 0;
                end else begin
                    ack_r = 1'b0;
                    wait_cnt++;
                end
            end else begin
                ack_r    = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    // Bounded wait for a done pulse; n is the number of cycles taken.
    task automatic wait_done(input bit side, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(side ? d_done : i_done) && n < 100);
    endtask

    int n;
    int d_before;
    int i_before;

    initial begin
        checks   = 0;
        errors   = 0;
        spur_ack = 1'b0;
        resp_lat = 0;
        Reset_N  = 1'b0;
        i_req    = 1'b1;
        d_req    = 1'b1;
        d_we     = 1'b0;
        i_addr   = 16'h0000;
        d_addr   = 16'h0000;
        d_wdata  = 64'h0;

        // Reset with both requests asserted
        step(2);
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_rd",    mem_readM, 0);
        check_eq("rst_wr",    mem_writeM, 0);
        check_eq("rst_addr",  mem_address, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_irdata", i_rdata, 0);
        check_eq("rst_drdata", d_rdata, 0);
        check_eq("rst_dones", {i_done, d_done}, 0);
        check_eq("rst_owner", owner, 0);
        i_req   = 1'b0;
        d_req   = 1'b0;
        Reset_N = 1'b1;
        step(1);

        // I read at 0x0013, ack every cycle
        i_req  = 1'b1;
        i_addr = 16'h0013;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check_eq($sformatf("ird_addr%0d", k), mem_address, 16'h0010 + 16'(k));
            check_eq($sformatf("ird_strb%0d", k), {mem_readM, mem_writeM, busy, owner, i_done}, 5'b10100);
        end
        step(1);
        check_eq("ird_done",  i_done, 1);
        check_eq("ird_ddone", d_done, 0);
        check_eq("ird_strb_off", {mem_readM, mem_writeM}, 0);
        check_eq("ird_line",  i_rdata, 64'h0113_0112_0111_0110);
        i_req = 1'b0;
        step(1);
        check_eq("ird_done_clr", i_done, 0);
        check_eq("ird_idle", busy, 0);

        // D write-back at 0x0024, ack two cycles after each address change
        resp_lat = 2;
        log_addr.delete();
        log_wdata.delete();
        log_we.delete();
        d_before = d_done_cnt;
        i_before = i_done_cnt;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0024;
        d_wdata = 64'h4444_3333_2222_1111;
        wait_done(1'b1, n);
        check_eq("dwr_latency", n, 13);
        d_req = 1'b0;
        check_eq("dwr_nwords", log_addr.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < log_addr.size()) begin
                check_eq($sformatf("dwr_addr%0d", k),  log_addr[k],  16'h0024 + 16'(k));
                check_eq($sformatf("dwr_wdata%0d", k), log_wdata[k], 16'h1111 * 16'(k + 1));
                check_eq($sformatf("dwr_we%0d", k),    log_we[k],    1);
            end
        end
        check_eq("dwr_drdata", d_rdata, 0);
        check_eq("dwr_irdata", i_rdata, 64'h0113_0112_0111_0110);
        step(2);
        check_eq("dwr_ndone",  d_done_cnt - d_before, 1);
        check_eq("dwr_nidone", i_done_cnt - i_before, 0);

        // Starvation: both requesting, D always re-requesting
        resp_lat = 0;
        grant_q.delete();
        d_we   = 1'b0;
        d_addr = 16'h0060;
        i_addr = 16'h0050;
        i_req  = 1'b1;
        d_req  = 1'b1;
        n = 0;
        while (grant_q.size() < 4 && n < 80) begin
            step(1);
            n++;
            if (i_done) i_req = 1'b0;
        end
        check_eq("stv_ngrants", grant_q.size(), 4);
        check_eq("stv_order", {grant_q.size() > 0 ? grant_q[0] : 1'bx,
                               grant_q.size() > 1 ? grant_q[1] : 1'bx,
                               grant_q.size() > 2 ? grant_q[2] : 1'bx,
                               grant_q.size() > 3 ? grant_q[3] : 1'bx}, 4'b1101);
        check_eq("stv_cnt_at_i", starve_at_i, 0);
        wait_done(1'b1, n);
        check_eq("stv_dlatency", n, 4);
        d_req = 1'b0;
        check_eq("stv_irdata", i_rdata, 64'h0153_0152_0151_0150);
        check_eq("stv_drdata", d_rdata, 64'h0163_0162_0161_0160);
        step(2);

        // Reset in the middle of a D read, after two acks
        d_before = d_done_cnt;
        d_addr = 16'h0030;
        d_req  = 1'b1;
        step(3);
        check_eq("rmo_addr_pre", mem_address, 16'h0032);
        Reset_N = 1'b0;
        d_req   = 1'b0;
        step(1);
        check_eq("rmo_busy", busy, 0);
        check_eq("rmo_strb", {mem_readM, mem_writeM}, 0);
        check_eq("rmo_addr", mem_address, 0);
        Reset_N = 1'b1;
        step(1);
        check_eq("rmo_nodone", d_done_cnt - d_before, 0);
        d_addr = 16'h0040;
        d_req  = 1'b1;
        step(1);
        check_eq("rmo_first_addr", mem_address, 16'h0040);
        check_eq("rmo_restart", {mem_readM, busy, owner}, 3'b111);
        wait_done(1'b1, n);
        check_eq("rmo_latency", n, 4);
        d_req = 1'b0;
        check_eq("rmo_drdata", d_rdata, 64'h0143_0142_0141_0140);
        step(2);

        // Spurious mem_ack while idle
        d_before = d_done_cnt;
        i_before = i_done_cnt;
        spur_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check_eq($sformatf("spur_idle%0d", k), {busy, mem_readM, mem_writeM, i_done, d_done}, 0);
        end
        spur_ack = 1'b0;
        check_eq("spur_ndone", (d_done_cnt - d_before) + (i_done_cnt - i_before), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
